// File: rtl/fast_circle_window_if.sv
// Pixel-stream input and circle-window output bundle for fast_circle_window.
// The master drives the raster stream; the slave (the window block) returns the circle bundle.
interface fast_circle_window_if #(
    parameter int PIX_W   = 8,
    parameter int COORD_W = 10
);
    logic [PIX_W-1:0]    i_din;
    logic                i_v;
    logic                i_sof;
    logic [COORD_W-1:0]  i_cols;
    logic [COORD_W-1:0]  i_rows;
    logic [16*PIX_W-1:0] o_circ;
    logic [PIX_W-1:0]    o_ctr;
    logic [COORD_W-1:0]  o_x;
    logic [COORD_W-1:0]  o_y;
    logic                o_v;
    logic                o_eof;
    logic                o_cfg_err;

    modport master (
        output i_din, i_v, i_sof, i_cols, i_rows,
        input  o_circ, o_ctr, o_x, o_y, o_v, o_eof, o_cfg_err
    );

    modport slave (
        input  i_din, i_v, i_sof, i_cols, i_rows,
        output o_circ, o_ctr, o_x, o_y, o_v, o_eof, o_cfg_err
    );
endinterface

// File: rtl/fast_circle_window.sv
// Radius-3 Bresenham circle window for the FAST front end: six line buffers feed a 7x7
// window; each accepted interior pixel yields the 16 circle pixels and the centre one cycle later.
module fast_circle_window #(
    parameter int PIX_W    = 8,
    parameter int MAX_COLS = 640,
    parameter int COORD_W  = 10
) (
    input logic i_clk,
    input logic i_rst,
    fast_circle_window_if.slave bus
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    // Window row/column of each circle point; row 0 is y-6, column 0 is x-6, centre is (3,3).
    localparam int CR [16] = '{0, 0, 1, 2, 3, 4, 5, 6, 6, 6, 5, 4, 3, 2, 1, 0};
    localparam int CC [16] = '{3, 4, 5, 6, 6, 6, 5, 4, 3, 2, 1, 0, 0, 0, 1, 2};

    state_t state_q, state_d;
    logic [COORD_W-1:0] x_q, y_q, cols_q, rows_q;
    logic [COORD_W-1:0] px, py, cols_cur, rows_cur, x_d, y_d;
    logic acc, err_set, last_pix, win_done, cfg_bad;

    logic [PIX_W-1:0] lb [6][MAX_COLS];
    logic [PIX_W-1:0] rd [6];
    logic [PIX_W-1:0] newcol [7];
    logic [PIX_W-1:0] win [7][7];
    logic [PIX_W-1:0] nwin [7][7];
    logic [16*PIX_W-1:0] circ_d;

    logic [16*PIX_W-1:0] circ_q;
    logic [PIX_W-1:0]    ctr_q;
    logic [COORD_W-1:0]  ox_q, oy_q;
    logic                ov_q, eof_q, err_q;

    assign cfg_bad = (bus.i_cols < COORD_W'(7)) ||
                     ({1'b0, bus.i_cols} > (COORD_W+1)'(MAX_COLS)) ||
                     (bus.i_rows < COORD_W'(7));

    // A start-of-frame pixel is taken in either state and restarts at (0,0) with fresh geometry.
    always_comb begin
        state_d  = state_q;
        acc      = 1'b0;
        err_set  = 1'b0;
        px       = x_q;
        py       = y_q;
        cols_cur = cols_q;
        rows_cur = rows_q;
        x_d      = x_q;
        y_d      = y_q;
        last_pix = 1'b0;
        win_done = 1'b0;
        if (bus.i_v && bus.i_sof) begin
            if (cfg_bad) begin
                err_set = 1'b1;
                state_d = IDLE;
            end else begin
                acc      = 1'b1;
                px       = '0;
                py       = '0;
                cols_cur = bus.i_cols;
                rows_cur = bus.i_rows;
                state_d  = ACTIVE;
            end
        end else if (bus.i_v && state_q == ACTIVE) begin
            acc = 1'b1;
        end
        last_pix = (px == cols_cur - COORD_W'(1)) && (py == rows_cur - COORD_W'(1));
        win_done = acc && (px >= COORD_W'(6)) && (py >= COORD_W'(6));
        if (px == cols_cur - COORD_W'(1)) begin
            x_d = '0;
            y_d = py + COORD_W'(1);
        end else begin
            x_d = px + COORD_W'(1);
            y_d = py;
        end
        if (acc && last_pix) state_d = IDLE;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cols_q  <= '0;
            rows_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (acc) begin
                x_q    <= x_d;
                y_q    <= y_d;
                cols_q <= cols_cur;
                rows_q <= rows_cur;
            end
            if (err_set) err_q <= 1'b1;
        end
    end

    // Line buffers cascade row by row: each one hands its old value at x to the next.
    always_comb begin
        for (int k = 0; k < 6; k++) rd[k] = lb[k][px];
    end

    always_ff @(posedge i_clk) begin
        if (acc) begin
            lb[0][px] <= bus.i_din;
            for (int k = 1; k < 6; k++) lb[k][px] <= rd[k-1];
        end
    end

    always_comb begin
        newcol[6] = bus.i_din;
        for (int k = 0; k < 6; k++) newcol[5-k] = rd[k];
        for (int r = 0; r < 7; r++) begin
            for (int c = 0; c < 6; c++) nwin[r][c] = win[r][c+1];
            nwin[r][6] = newcol[r];
        end
        circ_d = '0;
        for (int i = 0; i < 16; i++) circ_d[(15-i)*PIX_W +: PIX_W] = nwin[CR[i]][CC[i]];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int r = 0; r < 7; r++)
                for (int c = 0; c < 7; c++) win[r][c] <= '0;
        end else if (acc) begin
            win <= nwin;
        end
    end

    // Outputs are taken from the post-shift window so the bundle appears one cycle after acceptance.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            circ_q <= '0;
            ctr_q  <= '0;
            ox_q   <= '0;
            oy_q   <= '0;
            ov_q   <= 1'b0;
            eof_q  <= 1'b0;
        end else begin
            ov_q  <= win_done;
            eof_q <= acc && last_pix;
            if (win_done) begin
                circ_q <= circ_d;
                ctr_q  <= nwin[3][3];
                ox_q   <= px - COORD_W'(3);
                oy_q   <= py - COORD_W'(3);
            end
        end
    end

    assign bus.o_circ    = circ_q;
    assign bus.o_ctr     = ctr_q;
    assign bus.o_x       = ox_q;
    assign bus.o_y       = oy_q;
    assign bus.o_v       = ov_q;
    assign bus.o_eof     = eof_q;
    assign bus.o_cfg_err = err_q;
endmodule

// File: tb/tb_fast_circle_window.sv
// Scoreboard bench for fast_circle_window: a frame-level reference model pushes expected
// circle bundles; a negedge monitor pops and compares them whenever o_v is high.
module tb_fast_circle_window;
    localparam int PIX_W    = 8;
    localparam int MAX_COLS = 640;
    localparam int COORD_W  = 10;

    localparam int DX [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
    localparam int DY [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

    typedef struct packed {
        logic [COORD_W-1:0]  x;
        logic [COORD_W-1:0]  y;
        logic [PIX_W-1:0]    ctr;
        logic [16*PIX_W-1:0] circ;
        logic                eof;
    } exp_t;

    logic i_clk = 1'b0;
    logic i_rst;
    always #5 i_clk = ~i_clk;

    fast_circle_window_if #(.PIX_W(PIX_W), .COORD_W(COORD_W)) bus ();

    fast_circle_window #(.PIX_W(PIX_W), .MAX_COLS(MAX_COLS), .COORD_W(COORD_W)) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus  (bus.slave)
    );

    int tests  = 0;
    int fails  = 0;
    int vcount = 0;
    int ecount = 0;
    exp_t q[$];

    logic [PIX_W-1:0] img [16][MAX_COLS];
    bit m_active = 0;
    int m_x, m_y, m_cols, m_rows;

    logic [16*PIX_W-1:0] last_circ;
    logic [PIX_W-1:0]    last_ctr;
    logic [COORD_W-1:0]  last_x, last_y;

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per valid bundle and checks that outputs hold across gaps.
    always @(negedge i_clk) begin
        exp_t e;
        if (i_rst) begin
            q.delete();
            last_circ = '0;
            last_ctr  = '0;
            last_x    = '0;
            last_y    = '0;
        end else if (bus.o_v) begin
            vcount++;
            if (bus.o_eof) ecount++;
            if (q.size() == 0) begin
                check_output("unexpected_o_v", {bus.o_x, bus.o_y}, 128'hdead);
            end else begin
                e = q.pop_front();
                check_output("o_x", bus.o_x, e.x);
                check_output("o_y", bus.o_y, e.y);
                check_output("o_ctr", bus.o_ctr, e.ctr);
                check_output("o_circ", bus.o_circ, e.circ);
                check_output("o_eof", bus.o_eof, e.eof);
            end
            last_circ = bus.o_circ;
            last_ctr  = bus.o_ctr;
            last_x    = bus.o_x;
            last_y    = bus.o_y;
        end else begin
            if (bus.o_eof) begin
                ecount++;
                check_output("o_eof_without_o_v", bus.o_eof, 0);
            end
            if ({bus.o_circ, bus.o_ctr, bus.o_x, bus.o_y} !== {last_circ, last_ctr, last_x, last_y})
                check_output("hold_outputs", {bus.o_ctr, bus.o_x, bus.o_y}, {last_ctr, last_x, last_y});
        end
    end

    // Reference model: the frame is kept as an image; every interior pixel completes the
    // window centred three columns and rows back, read directly from the image.
    task automatic apply_stimulus(input logic [PIX_W-1:0] d, input logic sof, input int cols, input int rows);
        bit accept;
        int px, py;
        exp_t e;
        bus.i_din  = d;
        bus.i_v    = 1'b1;
        bus.i_sof  = sof;
        bus.i_cols = COORD_W'(cols);
        bus.i_rows = COORD_W'(rows);
        accept = 0;
        px = m_x;
        py = m_y;
        if (sof) begin
            if (cols < 7 || cols > MAX_COLS || rows < 7) begin
                m_active = 0;
            end else begin
                accept = 1;
                m_active = 1;
                m_cols = cols;
                m_rows = rows;
                px = 0;
                py = 0;
            end
        end else if (m_active) begin
            accept = 1;
        end
        if (accept) begin
            img[py][px] = d;
            if (px >= 6 && py >= 6) begin
                e.x    = COORD_W'(px - 3);
                e.y    = COORD_W'(py - 3);
                e.ctr  = img[py-3][px-3];
                e.circ = '0;
                for (int i = 0; i < 16; i++) e.circ[(15-i)*PIX_W +: PIX_W] = img[py-3+DY[i]][px-3+DX[i]];
                e.eof  = (px == m_cols - 1) && (py == m_rows - 1);
                q.push_back(e);
            end
            if (px == m_cols - 1 && py == m_rows - 1) m_active = 0;
            if (px == m_cols - 1) begin
                m_x = 0;
                m_y = py + 1;
            end else begin
                m_x = px + 1;
                m_y = py;
            end
        end
        @(posedge i_clk);
        #1;
        bus.i_v   = 1'b0;
        bus.i_sof = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        bus.i_v   = 1'b0;
        bus.i_sof = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic run_frame(input int cols, input int rows, input bit golden, input int gaps, input int npix);
        int n;
        logic [PIX_W-1:0] d;
        n = 0;
        for (int y = 0; y < rows; y++) begin
            for (int x = 0; x < cols; x++) begin
                if (n < npix) begin
                    d = golden ? PIX_W'((y << 4) | x) : PIX_W'($urandom);
                    apply_stimulus(d, (x == 0 && y == 0), cols, rows);
                    if (golden && gaps == 0 && x == 6 && y == 6) begin
                        check_output("gold_o_v", bus.o_v, 1);
                        check_output("gold_o_x", bus.o_x, 3);
                        check_output("gold_o_y", bus.o_y, 3);
                        check_output("gold_ctr", bus.o_ctr, 8'h33);
                        check_output("gold_circ0", bus.o_circ[127:120], 8'h03);
                        check_output("gold_circ4", bus.o_circ[95:88], 8'h36);
                        check_output("gold_circ8", bus.o_circ[63:56], 8'h63);
                        check_output("gold_circ12", bus.o_circ[31:24], 8'h30);
                    end
                    if (gaps > 0) idle_cycles(gaps);
                    n++;
                end
            end
        end
    endtask

    task automatic check_counts(input string name, input int v0, input int e0, input int wins, input int eofs);
        idle_cycles(3);
        check_output({name, "_windows"}, vcount - v0, wins);
        check_output({name, "_eofs"}, ecount - e0, eofs);
        check_output({name, "_queue_empty"}, q.size(), 0);
    endtask

    initial begin
        int v0, e0;
        bus.i_din  = '0;
        bus.i_v    = 1'b0;
        bus.i_sof  = 1'b0;
        bus.i_cols = '0;
        bus.i_rows = '0;
        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        check_output("reset_o_v", bus.o_v, 0);
        check_output("reset_cfg_err", bus.o_cfg_err, 0);
        i_rst = 1'b0;
        idle_cycles(2);

        v0 = vcount; e0 = ecount;
        run_frame(10, 8, 1, 0, 80);
        check_counts("golden", v0, e0, 8, 1);

        v0 = vcount; e0 = ecount;
        run_frame(10, 8, 1, 2, 80);
        check_counts("stall", v0, e0, 8, 1);

        v0 = vcount; e0 = ecount;
        run_frame(MAX_COLS, 7, 0, 0, MAX_COLS * 7);
        check_counts("max_width", v0, e0, MAX_COLS - 6, 1);

        v0 = vcount; e0 = ecount;
        run_frame(10, 8, 0, 0, 5 * 10 + 4);
        run_frame(12, 9, 0, 0, 12 * 9);
        check_counts("abort", v0, e0, 18, 1);

        v0 = vcount; e0 = ecount;
        apply_stimulus(8'h55, 1'b1, 6, 8);
        check_output("cfg_err_set", bus.o_cfg_err, 1);
        for (int i = 0; i < 10; i++) apply_stimulus(PIX_W'($urandom), 1'b0, 6, 8);
        check_counts("cfg_err_dropped", v0, e0, 0, 0);
        v0 = vcount; e0 = ecount;
        run_frame(7, 7, 0, 0, 49);
        check_counts("after_cfg_err", v0, e0, 1, 1);
        check_output("cfg_err_sticky", bus.o_cfg_err, 1);

        run_frame(8, 8, 0, 0, 60);
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        m_active = 0;
        @(negedge i_clk);
        check_output("midreset_o_v", bus.o_v, 0);
        check_output("midreset_o_eof", bus.o_eof, 0);
        check_output("midreset_o_x", bus.o_x, 0);
        check_output("midreset_cfg_err", bus.o_cfg_err, 0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        idle_cycles(1);
        v0 = vcount; e0 = ecount;
        run_frame(7, 7, 0, 0, 49);
        check_counts("post_reset", v0, e0, 1, 1);
        check_output("post_reset_o_x", bus.o_x, 3);
        check_output("post_reset_o_y", bus.o_y, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
